// File: rtl/collision_scheduler.sv
// Time-multiplexes one shared ball-pair collision unit over every pair once per frame.
// It issues one apply handshake per new contact and uses per-pair latches to suppress repeated bounces.
module collision_scheduler #(
  parameter int N_BALLS = 3,
  parameter int IDX_W   = 2,
  parameter int LAT     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  output logic [IDX_W-1:0] sel_a,
  output logic [IDX_W-1:0] sel_b,
  input  logic             coll_hit,
  output logic             apply_valid,
  input  logic             apply_ready,
  output logic [IDX_W-1:0] apply_a,
  output logic [IDX_W-1:0] apply_b,
  output logic             busy,
  output logic             done,
  output logic [7:0]       hit_count,
  output logic             overrun
);

  localparam int NPAIRS = N_BALLS * (N_BALLS - 1) / 2;
  localparam int PIDX_W = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam int WCNT_W = $clog2(LAT + 1);

  localparam logic [IDX_W-1:0]  LAST_A    = IDX_W'(N_BALLS - 2);
  localparam logic [IDX_W-1:0]  LAST_B    = IDX_W'(N_BALLS - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(LAT);

  typedef enum logic [1:0] {IDLE, SCAN, APPLY, DONE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    sel_a_q, sel_a_d;
  logic [IDX_W-1:0]    sel_b_q, sel_b_d;
  logic [IDX_W-1:0]    apply_a_q, apply_a_d;
  logic [IDX_W-1:0]    apply_b_q, apply_b_d;
  logic                apply_valid_q, apply_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          hit_count_q, hit_count_d;
  logic                overrun_q, overrun_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [PIDX_W-1:0]   pidx_q, pidx_d;
  logic [NPAIRS-1:0]   latch_q, latch_d;
  logic                advance;

  // NOTE: the contact latches are few flops, not a RAM, so they take the reset like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_a_q       <= '0;
      sel_b_q       <= IDX_W'(1);
      apply_a_q     <= '0;
      apply_b_q     <= '0;
      apply_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      hit_count_q   <= '0;
      overrun_q     <= 1'b0;
      wcnt_q        <= '0;
      pidx_q        <= '0;
      latch_q       <= '0;
    end else begin
      // NOTE: all state updates are non-blocking so every register sees pre-edge values.
      state_q       <= state_d;
      sel_a_q       <= sel_a_d;
      sel_b_q       <= sel_b_d;
      apply_a_q     <= apply_a_d;
      apply_b_q     <= apply_b_d;
      apply_valid_q <= apply_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      hit_count_q   <= hit_count_d;
      overrun_q     <= overrun_d;
      wcnt_q        <= wcnt_d;
      pidx_q        <= pidx_d;
      latch_q       <= latch_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold value first so no path through the case infers a latch.
    state_d     = state_q;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    apply_a_d   = apply_a_q;
    apply_b_d   = apply_b_q;
    hit_count_d = hit_count_q;
    overrun_d   = overrun_q;
    wcnt_d      = wcnt_q;
    pidx_d      = pidx_q;
    latch_d     = latch_q;
    advance     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = SCAN;
          sel_a_d = '0;
          sel_b_d = IDX_W'(1);
          wcnt_d  = '0;
          pidx_d  = '0;
        end
      end
      SCAN: begin
        if (wcnt_q == WCNT_LAST) begin
          if (coll_hit && !latch_q[pidx_q]) begin
            state_d   = APPLY;
            apply_a_d = sel_a_q;
            apply_b_d = sel_b_q;
          end else begin
            if (!coll_hit) latch_d[pidx_q] = 1'b0;
            advance = 1'b1;
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      APPLY: begin
        if (apply_ready) begin
          latch_d[pidx_q] = 1'b1;
          if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
          advance = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pair walk: bump b, wrapping to (a+1, a+2) at the last ball.
    if (advance) begin
      if (sel_a_q == LAST_A && sel_b_q == LAST_B) begin
        state_d = DONE;
      end else begin
        state_d = SCAN;
        wcnt_d  = '0;
        pidx_d  = pidx_q + PIDX_W'(1);
        if (sel_b_q == LAST_B) begin
          sel_a_d = sel_a_q + IDX_W'(1);
          sel_b_d = sel_a_q + IDX_W'(2);
        end else begin
          sel_b_d = sel_b_q + IDX_W'(1);
        end
      end
    end

    if (frame_tick && state_q != IDLE) overrun_d = 1'b1;

    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    apply_valid_d = (state_d == APPLY);
  end

  assign sel_a       = sel_a_q;
  assign sel_b       = sel_b_q;
  assign apply_a     = apply_a_q;
  assign apply_b     = apply_b_q;
  assign apply_valid = apply_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign hit_count   = hit_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Self-checking bench for collision_scheduler: a frame-level model predicts applies, pair order,
// dwell times, done latency, hit_count and overrun; a delayed collision-unit model drives coll_hit.
module tb_collision_scheduler;

  localparam int N_BALLS = 3;
  localparam int IDX_W   = 2;
  localparam int LAT     = 2;
  localparam int NPAIRS  = N_BALLS * (N_BALLS - 1) / 2;
  localparam int BUDGET  = 500;

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_tick;
  logic [IDX_W-1:0] sel_a, sel_b;
  logic             coll_hit;
  logic             apply_valid;
  logic             apply_ready;
  logic [IDX_W-1:0] apply_a, apply_b;
  logic             busy, done;
  logic [7:0]       hit_count;
  logic             overrun;

  collision_scheduler #(.N_BALLS(N_BALLS), .IDX_W(IDX_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .sel_a(sel_a), .sel_b(sel_b), .coll_hit(coll_hit),
    .apply_valid(apply_valid), .apply_ready(apply_ready),
    .apply_a(apply_a), .apply_b(apply_b),
    .busy(busy), .done(done), .hit_count(hit_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: scan order, contact memory, counters.
  int                  pa [NPAIRS];
  int                  pb [NPAIRS];
  bit                  contact [NPAIRS];
  int                  hits;
  bit                  exp_overrun;
  logic [NPAIRS-1:0]   cur_ovl;
  int                  stable;
  logic [2*IDX_W-1:0]  prev_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic int pair_of(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    for (int p = 0; p < NPAIRS; p++)
      if (pa[p] == int'(a) && pb[p] == int'(b)) return p;
    return -1;
  endfunction

  // Advance one cycle; outputs are read at the falling edge. coll_hit is only meaningful
  // once sel has been stable for LAT cycles, and is noise before that.
  task automatic step(input bit restart);
    int p;
    @(posedge clk);
    @(negedge clk);
    if (restart || {sel_a, sel_b} != prev_sel) stable = 0;
    else stable++;
    prev_sel = {sel_a, sel_b};
    p = pair_of(sel_a, sel_b);
    coll_hit = (stable >= LAT && p >= 0) ? cur_ovl[p] : 1'($urandom);
  endtask

  task automatic reset_model();
    for (int p = 0; p < NPAIRS; p++) contact[p] = 1'b0;
    hits = 0;
    exp_overrun = 1'b0;
  endtask

  // One full frame starting from an IDLE cycle. ovl[p] = pair p overlaps this frame,
  // wmax bounds the ready stall per apply, extra_tick = scan cycle of a stray tick (-1: none).
  task automatic run_frame(input logic [NPAIRS-1:0] ovl, input int wmax, input int extra_tick);
    int w        [NPAIRS];
    bit exp_app  [NPAIRS];
    int exp_run  [NPAIRS];
    int run_len  [NPAIRS];
    int val_len  [NPAIRS];
    int exp_done;
    int n;
    int p;
    int last_p;

    cur_ovl  = ovl;
    exp_done = NPAIRS * (LAT + 1) + 1;
    for (int q = 0; q < NPAIRS; q++) begin
      w[q]       = $urandom_range(wmax, 0);
      exp_app[q] = ovl[q] && !contact[q];
      exp_run[q] = LAT + 1;
      run_len[q] = 0;
      val_len[q] = 0;
      if (exp_app[q]) begin
        exp_run[q] += w[q] + 1;
        exp_done   += w[q] + 1;
        contact[q]  = 1'b1;
        hits        = (hits < 255) ? hits + 1 : 255;
      end else if (!ovl[q]) begin
        contact[q] = 1'b0;
      end
    end
    if (extra_tick >= 0) exp_overrun = 1'b1;

    frame_tick = 1'b1;
    step(1'b1);
    frame_tick = 1'b0;
    n      = 1;
    last_p = -1;
    while (!done && n < BUDGET) begin
      check("busy_scan", 32'(busy), 32'(1));
      p = pair_of(sel_a, sel_b);
      if (p != last_p) begin
        check("sel_order", 32'(p), 32'(last_p + 1));
        last_p = p;
      end
      if (p >= 0) run_len[p]++;
      if (apply_valid && p >= 0) begin
        val_len[p]++;
        check("apply_a", 32'(apply_a), 32'(pa[p]));
        check("apply_b", 32'(apply_b), 32'(pb[p]));
        apply_ready = (val_len[p] > w[p]);
      end else begin
        apply_ready = 1'($urandom);
      end
      frame_tick = (n == extra_tick);
      step(1'b0);
      n++;
    end
    frame_tick  = 1'b0;
    apply_ready = 1'b0;

    check("done_cycle", 32'(n), 32'(exp_done));
    check("done_sel_last", 32'(pair_of(sel_a, sel_b)), 32'(NPAIRS - 1));
    check("done_no_apply", 32'(apply_valid), 32'(0));
    for (int q = 0; q < NPAIRS; q++) begin
      check($sformatf("dwell_p%0d", q), 32'(run_len[q]), 32'(exp_run[q]));
      check($sformatf("valid_len_p%0d", q), 32'(val_len[q]), 32'(exp_app[q] ? w[q] + 1 : 0));
    end
    step(1'b0);
    check("done_pulse", 32'(done), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));
    check("hit_count", 32'(hit_count), 32'(hits));
    check("overrun", 32'(overrun), 32'(exp_overrun));
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    frame_tick  = 1'b0;
    coll_hit    = 1'b0;
    apply_ready = 1'b0;
    cur_ovl     = '0;
    stable      = 0;
    prev_sel    = '0;
    n = 0;
    for (int a = 0; a < N_BALLS; a++)
      for (int b = a + 1; b < N_BALLS; b++) begin
        pa[n] = a;
        pb[n] = b;
        n++;
      end
    reset_model();

    step(1'b0);
    step(1'b0);
    check("rst_sel_a", 32'(sel_a), 32'(0));
    check("rst_sel_b", 32'(sel_b), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_valid", 32'(apply_valid), 32'(0));
    check("rst_hits", 32'(hit_count), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    rst = 1'b0;
    step(1'b0);

    // Directed frames: no hits, stalled apply on (0,2), persistence, release/re-hit, stray tick.
    run_frame(3'b000, 0, -1);
    run_frame(3'b010, 3, -1);
    run_frame(3'b010, 0, -1);
    run_frame(3'b010, 0, -1);
    run_frame(3'b000, 0, -1);
    run_frame(3'b010, 1, -1);
    run_frame(3'b000, 0, 4);

    // Reset in the middle of an apply: latches for (0,1),(0,2) set, then (1,2) pending.
    run_frame(3'b011, 0, -1);
    cur_ovl     = 3'b111;
    apply_ready = 1'b0;
    frame_tick  = 1'b1;
    step(1'b1);
    frame_tick = 1'b0;
    n = 0;
    while (!apply_valid && n < 50) begin
      step(1'b0);
      n++;
    end
    check("rst_mid_wait_valid", 32'(apply_valid), 32'(1));
    check("rst_mid_pair_b", 32'(apply_b), 32'(2));
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    reset_model();
    check("rst_mid_valid", 32'(apply_valid), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_hits", 32'(hit_count), 32'(0));
    check("rst_mid_overrun", 32'(overrun), 32'(0));
    check("rst_mid_sel_a", 32'(sel_a), 32'(0));
    check("rst_mid_sel_b", 32'(sel_b), 32'(1));
    step(1'b0);
    run_frame(3'b111, 1, -1);

    // Random frames, then alternating full/empty frames to push hit_count into saturation.
    for (int f = 0; f < 140; f++)
      run_frame(NPAIRS'($urandom), 2,
                ($urandom_range(7, 0) == 0) ? int'($urandom_range(9, 1)) : -1);
    for (int f = 0; f < 200; f++)
      run_frame((f % 2 == 0) ? 3'b111 : 3'b000, 0, -1);
    check("hit_sat", 32'(hit_count), 32'(hits));
    check("hit_sat_value", 32'(hit_count), 32'(255));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
